// File: rtl/lru_age_tracker_pkg.sv
// Shared sizing helpers, reset ages and default geometry for the
// true-LRU age tracker.
package lru_pkg;

    localparam int DEF_WAYS = 4;
    localparam int DEF_SETS = 8;

    function automatic int way_w(input int ways);
        return $clog2(ways);
    endfunction

    function automatic int set_w(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    localparam int DEF_WAY_W = way_w(DEF_WAYS);
    localparam int DEF_SET_W = set_w(DEF_SETS);

    typedef logic [DEF_WAYS-1:0][DEF_WAY_W-1:0] age_vec_t;

    // Way i starts at age i, so way WAYS-1 is the first LRU victim.
    function automatic int reset_age(input int way);
        return way;
    endfunction

endpackage

// File: rtl/lru_victim_sel.sv
// Combinational victim picker: lowest free way first, else the oldest
// unpinned way; flags the case where every way is pinned.
module lru_victim_sel
    import lru_pkg::*;
#(
    parameter int  WAYS  = DEF_WAYS,
    localparam int WAY_W = way_w(WAYS)
) (
    input  logic [WAYS-1:0][WAY_W-1:0] age,
    input  logic [WAYS-1:0]            valid_mask,
    input  logic [WAYS-1:0]            pin_mask,
    output logic [WAY_W-1:0]           way,
    output logic                       none
);

    logic [WAYS-1:0]  free;
    logic             found;
    logic             have;
    logic [WAY_W-1:0] best_age;

    always_comb begin
        free     = ~valid_mask & ~pin_mask;
        none     = &pin_mask;
        way      = '0;
        found    = 1'b0;
        have     = 1'b0;
        best_age = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (free[i] && !found) begin
                way   = WAY_W'(i);
                found = 1'b1;
            end
        end
        // Ages are a permutation, so the strict compare never ties.
        if (!found) begin
            for (int i = 0; i < WAYS; i++) begin
                if (!pin_mask[i] && (!have || age[i] > best_age)) begin
                    way      = WAY_W'(i);
                    best_age = age[i];
                    have     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lru_age_tracker.sv
// Per-set true-LRU age vectors with touch update and a registered
// victim query that reads state before any same-cycle update.
module lru_age_tracker
    import lru_pkg::*;
#(
    parameter int  WAYS  = DEF_WAYS,
    parameter int  SETS  = DEF_SETS,
    localparam int WAY_W = way_w(WAYS),
    localparam int SET_W = set_w(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_en,
    input  logic             touch_en,
    input  logic [SET_W-1:0] touch_set,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             qry_en,
    input  logic [SET_W-1:0] qry_set,
    input  logic [WAYS-1:0]  qry_valid_mask,
    input  logic [WAYS-1:0]  qry_pin_mask,
    output logic             vic_valid,
    output logic [WAY_W-1:0] vic_way,
    output logic             vic_none
);

    typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;

    ages_t            ages [SETS];
    ages_t            rst_vec;
    ages_t            touch_cur;
    ages_t            touch_nxt;
    logic [WAY_W-1:0] sel_way;
    logic             sel_none;

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            rst_vec[i] = WAY_W'(reset_age(i));
        end
    end

    // Ways younger than the touched way age by one; it becomes MRU.
    always_comb begin
        touch_cur = ages[touch_set];
        touch_nxt = touch_cur;
        for (int i = 0; i < WAYS; i++) begin
            if (WAY_W'(i) == touch_way) begin
                touch_nxt[i] = '0;
            end else if (touch_cur[i] < touch_cur[touch_way]) begin
                touch_nxt[i] = touch_cur[i] + WAY_W'(1);
            end
        end
    end

    lru_victim_sel #(
        .WAYS(WAYS)
    ) u_sel (
        .age       (ages[qry_set]),
        .valid_mask(qry_valid_mask),
        .pin_mask  (qry_pin_mask),
        .way       (sel_way),
        .none      (sel_none)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                ages[s] <= rst_vec;
            end
            vic_valid <= 1'b0;
            vic_way   <= '0;
            vic_none  <= 1'b0;
        end else begin
            vic_valid <= qry_en;
            if (qry_en) begin
                vic_way  <= sel_way;
                vic_none <= sel_none;
            end
            if (flush_en) begin
                for (int s = 0; s < SETS; s++) begin
                    ages[s] <= rst_vec;
                end
            end else if (touch_en) begin
                ages[touch_set] <= touch_nxt;
            end
        end
    end

endmodule

// File: tb/tb_lru_age_tracker.sv
// Bench for lru_age_tracker: directed scenarios plus random traffic
// checked against a recency-list model of each set.
module tb_lru_age_tracker;

    logic       clk;
    logic       rst;
    logic       flush_en;
    logic       touch_en;
    logic [2:0] touch_set;
    logic [1:0] touch_way;
    logic       qry_en;
    logic [2:0] qry_set;
    logic [3:0] qry_valid_mask;
    logic [3:0] qry_pin_mask;
    logic       vic_valid;
    logic [1:0] vic_way;
    logic       vic_none;

    int checks = 0;
    int failures = 0;

    // Per set: ways ordered from most to least recently used.
    int lru_q [8][$];

    logic       exp_valid;
    logic [1:0] exp_way;
    logic       exp_none;

    lru_age_tracker #(
        .WAYS(4),
        .SETS(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_en      (flush_en),
        .touch_en      (touch_en),
        .touch_set     (touch_set),
        .touch_way     (touch_way),
        .qry_en        (qry_en),
        .qry_set       (qry_set),
        .qry_valid_mask(qry_valid_mask),
        .qry_pin_mask  (qry_pin_mask),
        .vic_valid     (vic_valid),
        .vic_way       (vic_way),
        .vic_none      (vic_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            lru_q[s].delete();
            for (int w = 0; w < 4; w++) lru_q[s].push_back(w);
        end
    endtask

    task automatic model_touch(input int s, input int w);
        int idx;
        idx = -1;
        for (int k = 0; k < lru_q[s].size(); k++) begin
            if (idx < 0 && lru_q[s][k] == w) idx = k;
        end
        if (idx >= 0) lru_q[s].delete(idx);
        lru_q[s].push_front(w);
    endtask

    task automatic model_victim(input int s, input logic [3:0] vm,
                                input logic [3:0] pm,
                                output logic [1:0] w, output logic n);
        bit found;
        found = 0;
        w = 2'd0;
        n = (pm == 4'hf);
        if (!n) begin
            for (int i = 0; i < 4; i++) begin
                if (!found && !vm[i] && !pm[i]) begin
                    w = 2'(i);
                    found = 1;
                end
            end
            for (int k = 3; k >= 0; k--) begin
                if (!found && !pm[lru_q[s][k]]) begin
                    w = 2'(lru_q[s][k]);
                    found = 1;
                end
            end
        end
    endtask

    task automatic drive(input logic f, input logic t, input int ts,
                         input int tw, input logic q, input int qs,
                         input logic [3:0] vm, input logic [3:0] pm);
        flush_en       = f;
        touch_en       = t;
        touch_set      = 3'(ts);
        touch_way      = 2'(tw);
        qry_en         = q;
        qry_set        = 3'(qs);
        qry_valid_mask = vm;
        qry_pin_mask   = pm;
        exp_valid      = q;
        if (q) model_victim(qs, vm, pm, exp_way, exp_none);
        @(posedge clk);
        #1;
        if (f) model_reset();
        else if (t) model_touch(ts, tw);
        flush_en = 1'b0;
        touch_en = 1'b0;
        qry_en   = 1'b0;
    endtask

    task automatic reset_cycle(input logic q);
        rst            = 1'b0;
        qry_en         = q;
        qry_set        = 3'd2;
        qry_valid_mask = 4'hf;
        qry_pin_mask   = 4'h0;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        qry_en    = 1'b0;
        model_reset();
        exp_valid = 1'b0;
        exp_way   = 2'd0;
        exp_none  = 1'b0;
    endtask

    task automatic test_reset();
        reset_cycle(1'b0);
        checks++;
        if ({vic_valid, vic_way, vic_none} !== 4'b0000) begin
            failures++;
            $display("FAIL reset got v=%b w=%0d n=%b want v=0 w=0 n=0",
                     vic_valid, vic_way, vic_none);
        end
        drive(0, 0, 0, 0, 1, 0, 4'hf, 4'h0);
        checks++;
        if (vic_valid !== 1'b1 || vic_way !== 2'd3 || vic_none !== 1'b0) begin
            failures++;
            $display("FAIL first_query got v=%b w=%0d n=%b want v=1 w=3 n=0",
                     vic_valid, vic_way, vic_none);
        end
        drive(0, 0, 0, 0, 0, 0, 4'hf, 4'h0);
        checks++;
        if (vic_valid !== 1'b0 || vic_way !== 2'd3 || vic_none !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got v=%b w=%0d n=%b want v=0 w=3 n=0",
                     vic_valid, vic_way, vic_none);
        end
    endtask

    task automatic test_touch();
        drive(0, 1, 2, 3, 0, 0, 4'hf, 4'h0);
        drive(0, 0, 0, 0, 1, 2, 4'hf, 4'h0);
        checks++;
        if (vic_valid !== 1'b1 || vic_way !== 2'd2) begin
            failures++;
            $display("FAIL touch_lru got v=%b w=%0d want v=1 w=2",
                     vic_valid, vic_way);
        end
        drive(0, 1, 2, 3, 0, 0, 4'hf, 4'h0);
        drive(0, 0, 0, 0, 1, 2, 4'hf, 4'h0);
        checks++;
        if (vic_valid !== 1'b1 || vic_way !== 2'd2) begin
            failures++;
            $display("FAIL touch_mru_again got v=%b w=%0d want v=1 w=2",
                     vic_valid, vic_way);
        end
    endtask

    task automatic test_victim_select();
        drive(0, 0, 0, 0, 1, 0, 4'b1011, 4'h0);
        checks++;
        if (vic_way !== 2'd2 || vic_none !== 1'b0) begin
            failures++;
            $display("FAIL invalid_first got w=%0d n=%b want w=2 n=0",
                     vic_way, vic_none);
        end
        drive(0, 0, 0, 0, 1, 0, 4'b1011, 4'b0100);
        checks++;
        if (vic_way !== 2'd3 || vic_none !== 1'b0) begin
            failures++;
            $display("FAIL pinned_invalid got w=%0d n=%b want w=3 n=0",
                     vic_way, vic_none);
        end
        drive(0, 0, 0, 0, 1, 0, 4'b1011, 4'b1111);
        checks++;
        if (vic_valid !== 1'b1 || vic_way !== 2'd0 || vic_none !== 1'b1) begin
            failures++;
            $display("FAIL all_pinned got v=%b w=%0d n=%b want v=1 w=0 n=1",
                     vic_valid, vic_way, vic_none);
        end
    endtask

    task automatic test_same_cycle();
        drive(0, 1, 1, 3, 1, 1, 4'hf, 4'h0);
        checks++;
        if (vic_way !== 2'd3 || vic_none !== 1'b0) begin
            failures++;
            $display("FAIL rbw_old_state got w=%0d n=%b want w=3 n=0",
                     vic_way, vic_none);
        end
        drive(0, 0, 0, 0, 1, 1, 4'hf, 4'h0);
        checks++;
        if (vic_way !== 2'd2) begin
            failures++;
            $display("FAIL rbw_new_state got w=%0d want w=2", vic_way);
        end
    endtask

    task automatic test_flush();
        for (int w = 3; w >= 0; w--) drive(0, 1, 0, w, 0, 0, 4'hf, 4'h0);
        drive(0, 0, 0, 0, 1, 0, 4'hf, 4'h0);
        checks++;
        if (vic_way !== 2'd3) begin
            failures++;
            $display("FAIL touch_seq got w=%0d want w=3", vic_way);
        end
        drive(1, 1, 0, 3, 1, 0, 4'hf, 4'h0);
        checks++;
        if (vic_valid !== 1'b1 || vic_way !== 2'd3) begin
            failures++;
            $display("FAIL flush_query got v=%b w=%0d want v=1 w=3",
                     vic_valid, vic_way);
        end
        drive(0, 1, 0, 0, 0, 0, 4'hf, 4'h0);
        drive(0, 0, 0, 0, 1, 0, 4'hf, 4'h0);
        checks++;
        if (vic_way !== 2'd3) begin
            failures++;
            $display("FAIL flush_beats_touch got w=%0d want w=3", vic_way);
        end
        drive(0, 0, 0, 0, 1, 2, 4'hf, 4'h0);
        checks++;
        if (vic_way !== 2'd3) begin
            failures++;
            $display("FAIL flush_all_sets got w=%0d want w=3", vic_way);
        end
    endtask

    task automatic test_reset_query();
        drive(0, 1, 2, 3, 0, 0, 4'hf, 4'h0);
        drive(0, 0, 0, 0, 1, 2, 4'hf, 4'b0001);
        checks++;
        if (vic_way !== 2'd2) begin
            failures++;
            $display("FAIL pre_reset got w=%0d want w=2", vic_way);
        end
        reset_cycle(1'b1);
        checks++;
        if ({vic_valid, vic_way, vic_none} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_beats_query got v=%b w=%0d n=%b want v=0 w=0 n=0",
                     vic_valid, vic_way, vic_none);
        end
        drive(0, 0, 0, 0, 1, 2, 4'hf, 4'h0);
        checks++;
        if (vic_valid !== 1'b1 || vic_way !== 2'd3) begin
            failures++;
            $display("FAIL post_reset_ages got v=%b w=%0d want v=1 w=3",
                     vic_valid, vic_way);
        end
    endtask

    task automatic test_back_to_back();
        logic       f;
        logic       t;
        logic       q;
        int         ts;
        int         qs;
        logic [3:0] vm;
        logic [3:0] pm;
        for (int n = 0; n < 600; n++) begin
            f  = ($urandom_range(0, 24) == 0);
            t  = $urandom_range(0, 1) == 1;
            q  = $urandom_range(0, 3) != 0;
            ts = $urandom_range(0, 7);
            qs = ($urandom_range(0, 2) == 0) ? ts : $urandom_range(0, 7);
            vm = 4'($urandom) | 4'($urandom);
            pm = ($urandom_range(0, 9) == 0) ? 4'hf
                 : 4'($urandom) & 4'($urandom);
            drive(f, t, ts, $urandom_range(0, 3), q, qs, vm, pm);
            checks++;
            if (vic_valid !== exp_valid || vic_way !== exp_way ||
                vic_none !== exp_none) begin
                failures++;
                $display("FAIL random[%0d] got v=%b w=%0d n=%b want v=%b w=%0d n=%b",
                         n, vic_valid, vic_way, vic_none,
                         exp_valid, exp_way, exp_none);
            end
        end
    endtask

    initial begin
        rst            = 1'b0;
        flush_en       = 1'b0;
        touch_en       = 1'b0;
        touch_set      = 3'd0;
        touch_way      = 2'd0;
        qry_en         = 1'b0;
        qry_set        = 3'd0;
        qry_valid_mask = 4'hf;
        qry_pin_mask   = 4'h0;
        test_reset();
        test_touch();
        test_victim_select();
        test_same_cycle();
        test_flush();
        test_reset_query();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lru_age_tracker.md
Name: lru_age_tracker

Overview:
- Parametrised true-LRU replacement tracker for a set-associative cache; successor to the fixed 4-way single-set LRU FSM.
- Holds one age vector per set (SETS sets × WAYS ways), updates it on cache hits/fills, and returns a registered victim way on query.
- Victim selection prefers invalid ways and honours a per-query pin (lock) mask.
- Sits beside the tag array in the M-stage cache; the cache controller drives touch/query.

Parameters:
WAYS, 4, associativity; power of two, ≥2
SETS, 8, number of sets; power of two, ≥1
WAY_W, $clog2(WAYS), way index / age width (derived, not overridden)
SET_W, max(1,$clog2(SETS)), set index width (derived)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
flush_en  in  1  reinitialise all age vectors to reset value
touch_en  in  1  record an access
touch_set  in  SET_W  set being accessed
touch_way  in  WAY_W  way being accessed (becomes MRU)
qry_en  in  1  request victim for qry_set
qry_set  in  SET_W  set queried
qry_valid_mask  in  WAYS  line-valid bits of queried set, bit i = way i
qry_pin_mask  in  WAYS  1 = way locked, never chosen
vic_valid  out  1  victim result valid (registered)
vic_way  out  WAY_W  chosen victim
vic_none  out  1  every way pinned; no victim

Behaviour:
- Ages: age 0 = MRU, WAYS-1 = LRU; each set's ages are always a permutation of 0..WAYS-1.
- Reset (rst=0 at clock edge): every set, way i age = i; vic_valid=0, vic_way=0, vic_none=0. rst has priority over all inputs.
- Flush (flush_en=1, rst=1): ages reinitialised as at reset; the registered outputs still respond to a same-cycle query, using pre-flush state.
- Touch (touch_en=1, no flush): in touch_set, every way with age < age[touch_way] increments; age[touch_way] becomes 0.
  - Touching the current MRU way leaves the state unchanged.
  - Other sets are unaffected.
  - flush_en overrides touch_en.
- Query: qry_en sampled at edge N; vic_valid=1 during cycle N+1 only, with vic_way/vic_none.
  - Latency is 1 cycle; a new query is accepted every cycle.
  - vic_valid=0 whenever qry_en was 0 at the prior edge.
  - vic_way/vic_none hold their last value while vic_valid=0.
- Victim selection, from state as it was before any same-cycle touch/flush (read-before-write):
  1. If any way is invalid and unpinned (~valid & ~pin), choose the lowest such index.
  2. Otherwise, choose the unpinned way with the greatest age.
  3. If all ways are pinned: vic_none=1, vic_way=0.
- Same-cycle touch and query to the same set: the query reflects the old state; the touch takes effect at the edge.
- Touch and query to different sets are independent.
- No handshake back-pressure. Out-of-range inputs cannot occur (power-of-two widths).

Decomposition:
- Package lru_pkg:
  - function for reset age of way i
  - localparam helpers for WAY_W/SET_W
  - typedef age_vec_t (WAYS × WAY_W)
- Sub-module lru_victim_sel: purely combinational. Inputs: age vector, valid mask, pin mask. Outputs: way, none.
- Top level holds the age register array, the touch update logic, and the output registers.

Test Plan (WAYS=4, SETS=8):
1. rst=0 for 1 cycle, then qry_en set 0, valid=4'b1111, pin=0 -> next cycle vic_valid=1, vic_way=3, vic_none=0.
2. touch set 2 way 3, then query set 2 (all valid, none pinned) -> vic_way=2 (ages 1,2,3,0); touch set 2 way 3 again -> query still gives 2.
3. Query set 0, valid=4'b1011 -> vic_way=2. Same with pin=4'b0100 -> vic_way=3. Pin=4'b1111 -> vic_none=1, vic_way=0.
4. Same cycle: touch set 1 way 3 + query set 1 -> vic_way=3. Next cycle query set 1 -> vic_way=2.
5. touch set 0 ways 3,2,1,0 in sequence -> query set 0 -> vic_way=3. Then flush_en + touch set 0 way 3 same cycle -> query -> vic_way=3, and a touch-only effect is absent (later query after touch way 0 -> 3).
6. qry_en=1 with rst=0 same edge -> next cycle vic_valid=0. After mid-sequence reset, touched sets return to reset ages (query set 2 -> 3).
